// File: rtl/prod_accumulator.sv
// Product accumulator: sums COUNT accepted unsigned products into one wide result
// and presents it on a valid/ready handshake, with a sticky wrap flag.

module prod_accumulator_chk #(
  parameter int ACC_W = 19
) (
  input logic             clk,
  input logic             rst_n,
  input logic             clr,
  input logic             out_valid,
  input logic             out_ready,
  input logic             prod_ready,
  input logic [ACC_W-1:0] acc_out
);

  // A presented result may only leave through a handshake or a clear.
  a_result_held: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready && !clr) |=> (out_valid && $stable(acc_out)));

  a_ready_decode: assert property (@(posedge clk) disable iff (!rst_n)
    prod_ready == !out_valid);

endmodule

module prod_accumulator #(
  parameter int PROD_W = 16,
  parameter int COUNT  = 8,
  parameter int ACC_W  = PROD_W + $clog2(COUNT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod_in,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              ovf,
  output logic [7:0]        cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // One spare bit above the wider operand captures the carry out of ACC_W.
  localparam int SUM_W = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
  // Nine bits so COUNT=256 is reachable; the port shows the low eight.
  localparam int CNT_W = 9;
  localparam logic [CNT_W-1:0] COUNT_C = CNT_W'(COUNT);

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] acc_out_q, acc_out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  logic [SUM_W-1:0] acc_base_s;
  logic [SUM_W-1:0] sum_s;
  logic             carry_s;
  logic             ovf_base_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             last_s;
  logic             accept_s;

  assign prod_ready = (state_q != S_DONE);
  assign accept_s   = prod_valid && prod_ready && !clr;

  // Shared adder: the IDLE load is the same add with a zero base.
  always_comb begin
    acc_base_s = {SUM_W{1'b0}};
    ovf_base_s = 1'b0;
    if (state_q == S_IDLE) begin
      acc_base_s = {SUM_W{1'b0}};
      ovf_base_s = 1'b0;
    end else begin
      acc_base_s = SUM_W'(acc_q);
      ovf_base_s = ovf_q;
    end
    sum_s     = acc_base_s + SUM_W'(prod_in);
    carry_s   = |sum_s[SUM_W-1:ACC_W];
    cnt_inc_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    last_s    = (cnt_inc_s == COUNT_C);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    acc_out_d   = acc_out_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    if (clr) begin
      state_d     = S_IDLE;
      acc_d       = {ACC_W{1'b0}};
      acc_out_d   = {ACC_W{1'b0}};
      cnt_d       = {CNT_W{1'b0}};
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_ACCUM: begin
          if (accept_s) begin
            acc_d = sum_s[ACC_W-1:0];
            cnt_d = cnt_inc_s;
            ovf_d = ovf_base_s | carry_s;
            if (last_s) begin
              acc_out_d   = sum_s[ACC_W-1:0];
              out_valid_d = 1'b1;
              state_d     = S_DONE;
            end else begin
              state_d = S_ACCUM;
            end
          end else begin
            state_d = state_q;
          end
        end
        S_DONE: begin
          // acc_out and ovf stay put; ovf clears on the next IDLE load.
          if (out_ready) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            cnt_d       = {CNT_W{1'b0}};
          end else begin
            state_d = S_DONE;
          end
        end
        default: begin
          state_d     = S_IDLE;
          acc_d       = {ACC_W{1'b0}};
          acc_out_d   = {ACC_W{1'b0}};
          cnt_d       = {CNT_W{1'b0}};
          ovf_d       = 1'b0;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= {ACC_W{1'b0}};
      acc_out_q   <= {ACC_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      acc_out_q   <= acc_out_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign acc_out   = acc_out_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;
  assign cnt       = cnt_q[7:0];

  prod_accumulator_chk #(.ACC_W(ACC_W)) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .out_valid  (out_valid_q),
    .out_ready  (out_ready),
    .prod_ready (prod_ready),
    .acc_out    (acc_out_q)
  );

endmodule

// File: doc/prod_accumulator.md
Name: prod_accumulator

Overview:
Downstream stage of the 8x8 adder-tree multiplier. It consumes the 16-bit product stream and sums COUNT consecutive accepted products into one wide result, which it presents on a valid/ready output handshake. Typical uses are dot products and FIR taps built around the multiplier.

Parameters:
PROD_W, 16, width of the incoming product.
COUNT, 8, number of products summed per result; legal range 1..256.
ACC_W, 19, accumulator and result width; default is PROD_W + clog2(COUNT), and smaller values are legal (wrap plus overflow flag).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear; highest priority after reset
prod_valid  input  1  prod_in holds a valid product this cycle
prod_in  input  PROD_W  unsigned product from the multiplier output register
prod_ready  output  1  block can accept a product this cycle
acc_out  output  ACC_W  completed sum, valid while out_valid=1
out_valid  output  1  result available
out_ready  input  1  consumer accepts the result
ovf  output  1  the current result wrapped past 2^ACC_W
cnt  output  8  products accepted toward the current result

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; acc, acc_out, cnt, ovf and out_valid are all 0.
- Accept: a product is accepted when prod_valid && prod_ready on a rising edge.
- prod_ready = (state != DONE). It is a combinational decode of the registered state.
- States:
  - IDLE: cnt=0. An accept loads acc<=prod_in zero-extended and sets cnt<=1. Next state is ACCUM, or DONE if COUNT=1.
  - ACCUM: an accept sets acc<=acc+prod_in mod 2^ACC_W and cnt<=cnt+1.
  - DONE transition: the accept that brings cnt to COUNT also loads acc_out with the final sum and goes to DONE. cnt stays at COUNT while in DONE.
  - Cycles with no accept leave all state unchanged; gaps in prod_valid are allowed.
  - DONE: out_valid=1. acc_out and ovf are held stable, and no products are accepted. When out_valid && out_ready, go to IDLE on the next edge: out_valid=0, cnt=0, prod_ready=1.
- Latency: last product accepted at edge t gives out_valid=1 after edge t, i.e. one cycle.
- Throughput: one result per COUNT+1 cycles minimum, since DONE costs one bubble.
- Overflow:
  - ovf is a sticky flag for the result in progress. It is set when any addition carries out of ACC_W bits.
  - ovf is cleared on the first accept of the next result (the IDLE load).
  - ovf is held with acc_out in DONE.
  - With default widths ovf can never set.
- clr=1 (synchronous) in any state: state=IDLE, acc=0, cnt=0, out_valid=0, ovf=0. acc_out is zeroed and any pending result is discarded. A product presented in the same cycle is not accepted, even though prod_ready=1.
- Reset asserted mid-accumulation or in DONE aborts immediately to reset values. No partial result is emitted after reset.
- prod_in is treated as unsigned. No signed support.
- out_valid must not drop without out_ready, except on clr or reset.

Test Plan:
- Default params, 8 consecutive accepts of prod_in=16'hFE01 (255*255) -> out_valid=1 one cycle after the 8th accept, acc_out=19'h7F008 (520200), ovf=0, cnt=8.
- Backpressure: after a completed result, out_ready=0 for 5 cycles with prod_valid=1 -> prod_ready=0, acc_out and out_valid held. Then out_ready=1 for 1 cycle -> out_valid=0 and prod_ready=1 next cycle. The next 8 products of 16'h0001 give acc_out=8.
- Gapped input: products 1..8 with prod_valid toggling 1,0,0,1,... -> acc_out=36 after the 8th accept, with no counting on idle cycles.
- clr after 3 accepts of 16'h0100, then 8 accepts of 16'h0002 -> acc_out=16, ovf=0. clr asserted with prod_valid=1 -> that product is dropped.
- ACC_W=16, COUNT=2: accepts 16'h8000, 16'h8001 -> acc_out=16'h0001, ovf=1. The next result 16'h0003+16'h0004 -> acc_out=7, ovf=0.
- Reset mid-operation (rst_n low after 5 accepts, asynchronous, mid-cycle) -> all outputs 0 immediately. COUNT=1 build: a single accept of 16'h1234 -> out_valid next cycle, acc_out=16'h1234.
